vga_sync_generator: RTL and testbench

Generates 640×480 @ 60 Hz VGA timing from the 25 MHz pixel clock for the DE1-SoC video path. Sits directly upstream of the pixel printer stage: it drives `pixel_x`, `pixel_y` and `video_on` into that stage, and `hsync_n`, `vsync_n`, `blank_n` and `sync_n` to the ADV7123 DAC pins. Horizontal and vertical timing are separate phase FSMs. An optional delay stage aligns the sync outputs with the printer's one-cycle registered RGB.

---
 rtl/vga_sync_generator_pkg.sv | 25 ++
 rtl/vga_sync_generator_if.sv | 24 ++
 rtl/vga_sync_generator_axis_counter.sv | 59 +++++
 rtl/vga_sync_generator.sv | 104 ++++++++++
 tb/tb_vga_sync_generator.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_sync_generator_pkg.sv
// rtl/vga_sync_generator_pkg.sv - 640x480@60 timing defaults and phase type for the VGA sync generator
package vga_pkg;

  localparam int VGA_CNT_W    = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } vga_phase_t;

endpackage

// File: rtl/vga_sync_generator_if.sv
// rtl/vga_sync_generator_if.sv - VGA timing bundle towards the pixel printer and the DAC pins
interface vga_sync_generator_if;
  import vga_pkg::*;

  logic [VGA_CNT_W-1:0] pixel_x;
  logic [VGA_CNT_W-1:0] pixel_y;
  logic                 video_on;
  logic                 frame_start;
  logic                 hsync_n;
  logic                 vsync_n;
  logic                 blank_n;
  logic                 sync_n;

  modport master (
    output pixel_x, pixel_y, video_on, frame_start,
    output hsync_n, vsync_n, blank_n, sync_n
  );

  modport slave (
    input pixel_x, pixel_y, video_on, frame_start,
    input hsync_n, vsync_n, blank_n, sync_n
  );

endinterface

// File: rtl/vga_sync_generator_axis_counter.sv
// rtl/vga_sync_generator_axis_counter.sv - one timing axis: counter plus ACTIVE/FRONT/SYNC/BACK phase FSM
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = VGA_H_ACTIVE,
  parameter int FRONT_LEN  = VGA_H_FRONT,
  parameter int SYNC_LEN   = VGA_H_SYNC,
  parameter int BACK_LEN   = VGA_H_BACK
) (
  input  logic                 vga_clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [VGA_CNT_W-1:0] count_o,
  output vga_phase_t           phase_o,
  output logic                 wrap_o
);

  localparam int W     = VGA_CNT_W;
  localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

  // Last count of each phase; the phase advances on the edge leaving that count.
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE_LEN - 1);
  localparam logic [W-1:0] FRONT_END  = W'(ACTIVE_LEN + FRONT_LEN - 1);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  vga_phase_t   phase_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= ACTIVE;
    end else begin
      count_q <= count_d;
      if (en) begin
        case (phase_q)
          ACTIVE: if (count_q == ACTIVE_END) phase_q <= FRONT;
          FRONT:  if (count_q == FRONT_END)  phase_q <= SYNC;
          SYNC:   if (count_q == SYNC_END)   phase_q <= BACK;
          BACK:   if (count_q == LAST)       phase_q <= ACTIVE;
        endcase
      end
    end
  end

  assign count_o = count_q;
  assign phase_o = phase_q;
  assign wrap_o  = en && (count_q == LAST);

endmodule

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - 640x480@60 VGA sync generator; VGA_PIPE_ALIGN_EN delays hsync_n/vsync_n/blank_n by one clock
module vga_sync_generator
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK
) (
  input  logic                  vga_clk,
  input  logic                  rst_n,
  vga_sync_generator_if.master  vga
);

  logic                 running_q;
  logic [VGA_CNT_W-1:0] h_count;
  logic [VGA_CNT_W-1:0] v_count;
  vga_phase_t           h_phase;
  vga_phase_t           v_phase;
  logic                 h_wrap;
  logic                 v_wrap;
  logic                 video_on;
  logic                 hsync_raw;
  logic                 vsync_raw;

  // First edge after reset release only arms the counters, so (0,0) is held one extra clock.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
    end else begin
      running_q <= 1'b1;
    end
  end

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FRONT_LEN  (H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .BACK_LEN   (H_BACK)
  ) u_h_counter (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .en      (running_q),
    .count_o (h_count),
    .phase_o (h_phase),
    .wrap_o  (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FRONT_LEN  (V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .BACK_LEN   (V_BACK)
  ) u_v_counter (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .en      (h_wrap),
    .count_o (v_count),
    .phase_o (v_phase),
    .wrap_o  (v_wrap)
  );

  assign video_on  = running_q && (h_phase == ACTIVE) && (v_phase == ACTIVE);
  assign hsync_raw = (h_phase != SYNC);
  assign vsync_raw = (v_phase != SYNC);

  assign vga.pixel_x     = h_count;
  assign vga.pixel_y     = v_count;
  assign vga.video_on    = video_on;
  assign vga.frame_start = running_q && (h_count == '0) && (v_count == '0);
  assign vga.sync_n      = 1'b0;

`ifdef VGA_PIPE_ALIGN_EN
  logic hsync_q;
  logic vsync_q;
  logic blank_q;

  // Matches the printer's registered RGB so DAC controls and colour land on the same clock.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      hsync_q <= hsync_raw;
      vsync_q <= vsync_raw;
      blank_q <= video_on;
    end
  end

  assign vga.hsync_n = hsync_q;
  assign vga.vsync_n = vsync_q;
  assign vga.blank_n = blank_q;
`else
  assign vga.hsync_n = hsync_raw;
  assign vga.vsync_n = vsync_raw;
  assign vga.blank_n = video_on;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - directed self-checking bench for vga_sync_generator (vertical timing shortened)
module tb_vga_sync_generator;

  localparam int H_TOT  = 800;
  localparam int V_ACT  = 6;
  localparam int V_FR   = 2;
  localparam int V_SY   = 2;
  localparam int V_BK   = 3;
  localparam int V_TOT  = 13;
  localparam int FRAME  = 10400;
`ifdef VGA_PIPE_ALIGN_EN
  localparam bit LAG = 1'b1;
`else
  localparam bit LAG = 1'b0;
`endif

  logic vga_clk;
  logic rst_n;
  vga_sync_generator_if vif();

  vga_sync_generator #(
    .V_ACTIVE (V_ACT),
    .V_FRONT  (V_FR),
    .V_SYNC   (V_SY),
    .V_BACK   (V_BK)
  ) dut (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .vga     (vif)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  int checks   = 0;
  int failures = 0;

  int cyc, mx, my, pmx, pmy;
  int hs_low, hs_first, vo_cnt, vs_low;
  int fs_cnt, fs_last, fs_int1, fs_int2;
  int err_x, err_y, err_vo, err_fs, err_hs, err_vs, err_bl, err_sync;
  bit found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge vga_clk);
    #1;
  endtask

  function automatic logic f_vo(input int x, input int y);
    return (x < 640) && (y < V_ACT);
  endfunction

  function automatic logic f_hs(input int x);
    return !((x >= 656) && (x <= 751));
  endfunction

  function automatic logic f_vs(input int y);
    return !((y >= V_ACT + V_FR) && (y < V_ACT + V_FR + V_SY));
  endfunction

  task automatic measure();
    if (cyc < H_TOT && vif.hsync_n == 1'b0) begin
      hs_low++;
      if (hs_first < 0) hs_first = cyc;
    end
    if (cyc < H_TOT && vif.video_on == 1'b1) vo_cnt++;
    if (cyc < FRAME && vif.vsync_n == 1'b0) vs_low++;
    if (vif.frame_start == 1'b1) begin
      if (fs_cnt == 1) fs_int1 = cyc - fs_last;
      if (fs_cnt == 2) fs_int2 = cyc - fs_last;
      fs_last = cyc;
      fs_cnt++;
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_x"},     32'(vif.pixel_x), 0);
    chk({pfx, "_y"},     32'(vif.pixel_y), 0);
    chk({pfx, "_vo"},    32'(vif.video_on), 0);
    chk({pfx, "_fs"},    32'(vif.frame_start), 0);
    chk({pfx, "_blank"}, 32'(vif.blank_n), 0);
    chk({pfx, "_hs"},    32'(vif.hsync_n), 1);
    chk({pfx, "_vs"},    32'(vif.vsync_n), 1);
    chk({pfx, "_sync"},  32'(vif.sync_n), 0);
  endtask

  task automatic chk_startup(input string pfx);
    chk({pfx, "_pre_x"},  32'(vif.pixel_x), 0);
    chk({pfx, "_pre_vo"}, 32'(vif.video_on), 0);
    chk({pfx, "_pre_fs"}, 32'(vif.frame_start), 0);
    tick();
    chk({pfx, "_e0_x"},     32'(vif.pixel_x), 0);
    chk({pfx, "_e0_y"},     32'(vif.pixel_y), 0);
    chk({pfx, "_e0_vo"},    32'(vif.video_on), 1);
    chk({pfx, "_e0_fs"},    32'(vif.frame_start), 1);
    chk({pfx, "_e0_blank"}, 32'(vif.blank_n), LAG ? 0 : 1);
    chk({pfx, "_e0_hs"},    32'(vif.hsync_n), 1);
    tick();
    chk({pfx, "_e1_x"},     32'(vif.pixel_x), 1);
    chk({pfx, "_e1_y"},     32'(vif.pixel_y), 0);
    chk({pfx, "_e1_fs"},    32'(vif.frame_start), 0);
    chk({pfx, "_e1_blank"}, 32'(vif.blank_n), 1);
  endtask

  task automatic step_model();
    tick();
    cyc++;
    pmx = mx;
    pmy = my;
    if (mx == H_TOT - 1) begin
      mx = 0;
      my = (my == V_TOT - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    if (32'(vif.pixel_x) !== mx) err_x++;
    if (32'(vif.pixel_y) !== my) err_y++;
    if (vif.video_on !== f_vo(mx, my)) err_vo++;
    if (vif.frame_start !== (mx == 0 && my == 0)) err_fs++;
    if (vif.hsync_n !== (LAG ? f_hs(pmx) : f_hs(mx))) err_hs++;
    if (vif.vsync_n !== (LAG ? f_vs(pmy) : f_vs(my))) err_vs++;
    if (vif.blank_n !== (LAG ? f_vo(pmx, pmy) : f_vo(mx, my))) err_bl++;
    if (vif.sync_n !== 1'b0) err_sync++;
  endtask

  initial begin
    rst_n = 1'b0;
    hs_low = 0; hs_first = -1; vo_cnt = 0; vs_low = 0;
    fs_cnt = 0; fs_last = -1; fs_int1 = 0; fs_int2 = 0;
    err_x = 0; err_y = 0; err_vo = 0; err_fs = 0;
    err_hs = 0; err_vs = 0; err_bl = 0; err_sync = 0;
    repeat (3) tick();
    chk_reset_vals("rst");

    rst_n = 1'b1;
    chk_startup("start");

    // Re-observe the first two samples for the line/frame measurements.
    cyc = 0;
    mx = 0; my = 0;
    hs_low = 0; vo_cnt = 2; fs_cnt = 1; fs_last = 0;
    cyc = 1; mx = 1;

    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step_model();
      measure();
      if (cyc == H_TOT - 1) begin
        chk("line_end_x", 32'(vif.pixel_x), 799);
        chk("line_end_y", 32'(vif.pixel_y), 0);
      end
      if (cyc == H_TOT) begin
        chk("line_wrap_x", 32'(vif.pixel_x), 0);
        chk("line_wrap_y", 32'(vif.pixel_y), 1);
      end
      if (cyc == FRAME - 1) begin
        chk("frame_end_x", 32'(vif.pixel_x), 799);
        chk("frame_end_y", 32'(vif.pixel_y), V_TOT - 1);
        chk("frame_end_fs", 32'(vif.frame_start), 0);
      end
      if (cyc == FRAME) begin
        chk("frame_wrap_x", 32'(vif.pixel_x), 0);
        chk("frame_wrap_y", 32'(vif.pixel_y), 0);
        chk("frame_wrap_fs", 32'(vif.frame_start), 1);
      end
    end

    chk("hsync_low_len", hs_low, 96);
    chk("hsync_first_x", hs_first, 656 + int'(LAG));
    chk("video_on_len", vo_cnt, 640);
    chk("vsync_low_len", vs_low, 1600);
    chk("fs_pulses", fs_cnt, 3);
    chk("fs_interval1", fs_int1, FRAME);
    chk("fs_interval2", fs_int2, FRAME);
    chk("err_x", err_x, 0);
    chk("err_y", err_y, 0);
    chk("err_video_on", err_vo, 0);
    chk("err_frame_start", err_fs, 0);
    chk("err_hsync", err_hs, 0);
    chk("err_vsync", err_vs, 0);
    chk("err_blank", err_bl, 0);
    chk("err_sync_n", err_sync, 0);

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step_model();
      if (mx == 300 && my == 4) found = 1'b1;
    end
    chk("midframe_reached", 32'(found), 1);
    chk("midframe_x", 32'(vif.pixel_x), 300);
    chk("midframe_y", 32'(vif.pixel_y), 4);
    chk("midframe_vo", 32'(vif.video_on), 1);

    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) tick();
    chk_reset_vals("midrst_hold");
    rst_n = 1'b1;
    chk_startup("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
